// File: rtl/axis_meas_streamer.sv
// AXI-Stream master: queues raw-sample and block-mean requests, emits tagged beats.
// Optional header beat with a sequence number when AXIS_STREAMER_HEADER_EN is defined.
module axis_meas_streamer #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int MEAN_LOG2  = 3,
  parameter int DROP_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_W-1:0]             data_in,
  input  logic                          data_valid,
  input  logic                          send_packet,
  input  logic                          send_mean,
  output logic [DATA_W-1:0]             m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tuser,
  output logic [DATA_W-1:0]             mean_out,
  output logic                          mean_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [DROP_W-1:0]             drop_cnt
);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;
  localparam int ACC_W = DATA_W + MEAN_LOG2;
  localparam int CNT_W = (MEAN_LOG2 > 0) ? MEAN_LOG2 : 1;

`ifdef AXIS_STREAMER_HEADER_EN
  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA} state_t;
`endif

  state_t              state, state_nxt;
  logic [ACC_W-1:0]    acc, acc_sum;
  logic [CNT_W-1:0]    smp_cnt;
  logic [DATA_W:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic                full, empty, space, pop;
  logic                wr_en, drop, mean_pend, mean_pend_nxt;
  logic [DATA_W:0]     wr_dat;
  logic [DATA_W-1:0]   out_dat;
  logic                out_user;

  // Block mean: the last sample of a block is folded in on the same edge it arrives.
  assign acc_sum = acc + ACC_W'(data_in);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      smp_cnt    <= '0;
      mean_out   <= '0;
      mean_valid <= 1'b0;
    end else if (data_valid) begin
      if (smp_cnt == CNT_W'((1 << MEAN_LOG2) - 1)) begin
        mean_out   <= DATA_W'(acc_sum >> MEAN_LOG2);
        acc        <= '0;
        smp_cnt    <= '0;
        mean_valid <= 1'b1;
      end else begin
        acc     <= acc_sum;
        smp_cnt <= smp_cnt + 1'b1;
      end
    end
  end

  assign full  = (fifo_level == LW'(FIFO_DEPTH));
  assign empty = (fifo_level == '0);
  assign space = !full || pop;

  // Raw requests take priority; a displaced mean request parks in mean_pend.
  always_comb begin
    wr_en         = 1'b0;
    wr_dat        = '0;
    drop          = 1'b0;
    mean_pend_nxt = mean_pend;
    if (send_packet) begin
      if (space) begin
        wr_en  = 1'b1;
        wr_dat = {1'b0, data_in};
      end else begin
        drop = 1'b1;
      end
      if (send_mean) mean_pend_nxt = 1'b1;
    end else if (mean_pend || send_mean) begin
      if (space) begin
        wr_en         = 1'b1;
        wr_dat        = {1'b1, mean_out};
        mean_pend_nxt = 1'b0;
      end else if (!mean_pend) begin
        drop = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      mean_pend  <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      mean_pend <= mean_pend_nxt;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop = 1'b1;
`ifdef AXIS_STREAMER_HEADER_EN
        state_nxt = HDR;
`else
        state_nxt = DATA;
`endif
      end
`ifdef AXIS_STREAMER_HEADER_EN
      HDR:  if (m_axis_tready) state_nxt = DATA;
`endif
      DATA: if (m_axis_tready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_dat  <= '0;
      out_user <= 1'b0;
    end else if (pop) begin
      {out_user, out_dat} <= mem[rd_ptr];
    end
  end

  assign m_axis_tvalid = (state != IDLE);
  assign m_axis_tlast  = (state == DATA);
  assign m_axis_tuser  = out_user;

`ifdef AXIS_STREAMER_HEADER_EN
  logic [15:0]       seq;
  logic [DATA_W-1:0] hdr_word;

  always_ff @(posedge clk) begin
    if (rst)                                seq <= '0;
    else if (state == DATA && m_axis_tready) seq <= seq + 1'b1;
  end

  always_comb begin
    hdr_word        = '0;
    hdr_word[31:24] = 8'hA5;
    hdr_word[16]    = out_user;
    hdr_word[15:0]  = seq;
  end

  assign m_axis_tdata = (state == HDR) ? hdr_word : out_dat;
`else
  assign m_axis_tdata = out_dat;
`endif

endmodule

// File: tb/tb_axis_meas_streamer.sv
// Directed bench for axis_meas_streamer (default build, header build under AXIS_STREAMER_HEADER_EN).
module tb_axis_meas_streamer;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic        data_valid, send_packet, send_mean;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
  logic [31:0] mean_out;
  logic        mean_valid;
  logic [3:0]  fifo_level;
  logic [15:0] drop_cnt;

  int n_chk = 0;
  int n_err = 0;

  axis_meas_streamer #(.DATA_W(32), .FIFO_DEPTH(8), .MEAN_LOG2(3), .DROP_W(16)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .send_packet(send_packet), .send_mean(send_mean),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .mean_out(mean_out), .mean_valid(mean_valid),
    .fifo_level(fifo_level), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a valid beat, checks it, then lets the handshake edge pass.
  task automatic expect_beat(input string tag, input logic [31:0] d, input logic u);
    for (int i = 0; i < 20 && !m_axis_tvalid; i++) tick();
    chk({tag, "_vld"},  m_axis_tvalid, 1);
    chk({tag, "_dat"},  m_axis_tdata,  d);
    chk({tag, "_user"}, m_axis_tuser,  u);
    chk({tag, "_last"}, m_axis_tlast,  1);
    tick();
  endtask

  task automatic raw_beat(input string tag, input logic [31:0] d);
    data_in = d; send_packet = 1'b1;
    tick();
    send_packet = 1'b0;
    chk({tag, "_lvl1"}, fifo_level, 1);
    chk({tag, "_novld"}, m_axis_tvalid, 0);
    tick();
    chk({tag, "_vld_k1"}, m_axis_tvalid, 1);
    expect_beat(tag, d, 1'b0);
    chk({tag, "_idle"}, m_axis_tvalid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; data_in = '0; data_valid = 1'b0; send_packet = 1'b0;
    send_mean = 1'b0; m_axis_tready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata",  m_axis_tdata, 0);
    chk("rst_level",  fifo_level, 0);
    chk("rst_drop",   drop_cnt, 0);
    chk("rst_mvld",   mean_valid, 0);
    chk("rst_mean",   mean_out, 0);

`ifdef AXIS_STREAMER_HEADER_EN
    for (int p = 0; p < 2; p++) begin
      data_in = 32'h1111_0000 + p; send_packet = 1'b1;
      tick();
      send_packet = 1'b0;
      tick();
      chk("hdr_vld",  m_axis_tvalid, 1);
      chk("hdr_dat",  m_axis_tdata, 32'hA500_0000 + p);
      chk("hdr_last", m_axis_tlast, 0);
      chk("hdr_user", m_axis_tuser, 0);
      tick();
      chk("hd_dat",  m_axis_tdata, 32'h1111_0000 + p);
      chk("hd_last", m_axis_tlast, 1);
      tick();
      chk("hd_idle", m_axis_tvalid, 0);
    end
`else
    raw_beat("raw0", 32'hAABBCCDD);
    raw_beat("raw1", 32'h12341234);
    raw_beat("raw2", 32'h55AA55AA);

    for (int i = 1; i <= 8; i++) begin
      data_in = 32'(10 * i); data_valid = 1'b1;
      tick();
      if (i == 7) chk("mean_vld_early", mean_valid, 0);
    end
    data_valid = 1'b0;
    chk("mean_out", mean_out, 45);
    chk("mean_vld", mean_valid, 1);
    send_mean = 1'b1;
    tick();
    send_mean = 1'b0;
    expect_beat("mean_beat", 32'd45, 1'b1);

    // Occupy the output with a stalled beat so both requests stay queued.
    m_axis_tready = 1'b0;
    data_in = 32'h0F0F; send_packet = 1'b1;
    tick();
    send_packet = 1'b0;
    tick();
    data_in = 32'h100; send_packet = 1'b1; send_mean = 1'b1;
    tick();
    send_packet = 1'b0; send_mean = 1'b0;
    chk("both_lvl1", fifo_level, 1);
    tick();
    chk("both_lvl2", fifo_level, 2);
    chk("both_stall", m_axis_tdata, 32'h0F0F);
    m_axis_tready = 1'b1;
    expect_beat("both0", 32'h0F0F, 1'b0);
    expect_beat("both1", 32'h100, 1'b0);
    expect_beat("both2", 32'd45, 1'b1);

    m_axis_tready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      data_in = 32'h200 + i; send_packet = 1'b1;
      tick();
    end
    send_packet = 1'b0;
    chk("full_lvl",  fifo_level, 8);
    chk("full_drop", drop_cnt, 1);
    for (int i = 0; i < 3; i++) begin
      chk("stall_vld", m_axis_tvalid, 1);
      chk("stall_dat", m_axis_tdata, 32'h200);
      tick();
    end
    m_axis_tready = 1'b1;
    for (int i = 0; i < 9; i++) expect_beat("drain", 32'h200 + i, 1'b0);
    chk("drain_lvl", fifo_level, 0);

    begin
      logic [31:0] q[$];
      int issued = 0, rcvd = 0;
      for (int cyc = 0; cyc < 5000 && (issued < 200 || q.size() > 0); cyc++) begin
        m_axis_tready = (issued < 200) ? ($urandom_range(9) < 7) : 1'b1;
        if (m_axis_tvalid && m_axis_tready) begin
          chk("rnd_dat", m_axis_tdata, (q.size() > 0) ? q[0] : 32'hDEAD_BEEF);
          chk("rnd_user", m_axis_tuser, 0);
          if (q.size() > 0) void'(q.pop_front());
          rcvd++;
        end
        send_packet = 1'b0;
        if (issued < 200 && q.size() < 8 && $urandom_range(1)) begin
          data_in = $urandom;
          send_packet = 1'b1;
          q.push_back(data_in);
          issued++;
        end
        tick();
      end
      send_packet = 1'b0;
      chk("rnd_count", rcvd, 200);
      chk("rnd_drop", drop_cnt, 1);
    end

    m_axis_tready = 1'b0;
    data_in = 32'h77; send_packet = 1'b1;
    tick();
    tick();
    tick();
    send_packet = 1'b0;
    chk("mid_vld", m_axis_tvalid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_vld",  m_axis_tvalid, 0);
    chk("mrst_lvl",  fifo_level, 0);
    chk("mrst_drop", drop_cnt, 0);
    chk("mrst_mvld", mean_valid, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/axis_meas_streamer.md
Name: axis_meas_streamer

Overview:
Parametrised AXI-Stream master for the frequency-meter datapath; next generation of the single-word packet sender.
- Buffers raw-sample and mean-value requests in an internal FIFO and drains them as tagged AXI-Stream beats, with correct tvalid/tready backpressure.
- Computes a block mean over 2^MEAN_LOG2 measurement samples in hardware.
- Sits between the measurement core and the downstream AXI-Stream sink (DMA/UART bridge).

Parameters:
DATA_W, 32, sample and tdata width in bits; must be at least 32.
FIFO_DEPTH, 8, request FIFO entries; power of two, at least 2.
MEAN_LOG2, 3, mean computed over 2^MEAN_LOG2 valid samples.
DROP_W, 16, width of the dropped-request counter.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
data_in  in  DATA_W  current measurement sample
data_valid  in  1  data_in holds a new sample this cycle (feeds mean accumulator)
send_packet  in  1  request: enqueue data_in as a raw beat
send_mean  in  1  request: enqueue latest block mean
m_axis_tdata  out  DATA_W  stream data
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready from sink
m_axis_tlast  out  1  last beat of packet
m_axis_tuser  out  1  beat type: 0 = raw sample, 1 = mean
mean_out  out  DATA_W  latest latched mean
mean_valid  out  1  at least one full mean block completed since reset
fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
drop_cnt  out  DROP_W  saturating count of requests lost to a full FIFO

Behaviour:
- Reset (rst high at a clk edge): every output is 0. FIFO, pending flag, accumulator, sample counter, drop_cnt and sequence counter are cleared. A beat in flight is abandoned, so the sink sees tvalid fall.
- Mean unit:
  - On each data_valid, acc += data_in; acc is DATA_W+MEAN_LOG2 bits and never overflows.
  - On the 2^MEAN_LOG2-th sample: mean_out <= (acc + data_in) >> MEAN_LOG2, truncated. acc restarts at 0 and mean_valid <= 1.
  - Non-overlapping blocks.
- FIFO: entries are {type, data}, DATA_W+1 bits.
  - Raw entry is {0, data_in} sampled at the request edge.
  - Mean entry is {1, mean_out} as registered at the write edge; it is 0 until mean_valid.
- Request arbitration, one FIFO write per cycle:
  - send_packet only: raw write.
  - send_mean only: mean write.
  - Both in the same cycle: raw written, mean_pend set; mean written on the next edge where the FIFO has space and no new send_packet arrives. A raw request always wins.
  - send_mean while mean_pend=1 is merged (no second entry).
  - Request with the FIFO full: entry not written, drop_cnt += 1, saturating at all-ones. A blocked mean_pend waits; it is not dropped.
  - Simultaneous write and read on a full FIFO is allowed (level unchanged).
- Output FSM: states IDLE, DATA (plus HDR with the optional feature).
  - IDLE: if FIFO non-empty, pop the head into the output register and go to DATA at the next edge.
  - DATA: tvalid=1; tdata, tuser and tlast are held stable while tready=0. On tvalid&tready, go to IDLE.
  - tlast=1 on every DATA beat.
- Latency: request at edge k into an empty FIFO → FIFO write at k, output load at k+1, tvalid high from k+1.
- Throughput: one beat per 2 cycles (IDLE reload). tvalid never depends combinationally on tready.
- fifo_level and drop_cnt are registered and update on the edge of the write/pop.

Optional Feature:
Macro AXIS_STREAMER_HEADER_EN.
- Defined: each FIFO entry becomes a 2-beat packet with FSM path IDLE → HDR → DATA.
  - Header beat: tdata[31:24]=8'hA5, tdata[16]=entry type, tdata[15:0]=seq, remaining bits 0; tuser=type, tlast=0.
  - Data beat follows with tlast=1.
  - seq is 16 bits, starts at 0, increments on each completed data-beat handshake, and wraps 0xFFFF → 0x0000.
- Not defined: no header, single-beat packets, no seq register.

Test Plan:
- Reset then 3 isolated send_packet with data 0xAABBCCDD, 0x12341234, 0x55AA55AA, tready=1 → three beats in order, tuser=0, tlast=1, first tvalid one cycle after the request edge.
- 8 data_valid samples 10,20,...,80 (MEAN_LOG2=3), then send_mean → mean_out=45, mean_valid=1, one beat tdata=45, tuser=1.
- send_packet and send_mean in the same cycle (data 0x100, mean 45) → beat 0x100/tuser0 then 45/tuser1; fifo_level peaks at 2 with tready=0.
- tready=0, 10 send_packet requests (FIFO_DEPTH=8) → first pop moves one entry out, FIFO fills to 8, drop_cnt=1; after tready=1, 9 beats drained with tdata stable during stalls.
- Random 70% tready, 200 requests → scoreboard order and data match, no beat lost or duplicated beyond drop_cnt; assert rst mid-beat → tvalid=0, fifo_level=0 on the next edge.
- With AXIS_STREAMER_HEADER_EN: two raw requests → header 0xA5000000 then data, header 0xA5000001 then data; tlast only on data beats.
